voice_tdm_nco_bank: RTL
=======================

Name: voice_tdm_nco_bank

Overview:
Parametrised bank of NUM_VOICES time-multiplexed NCOs for the poly synth.
- One shared arithmetic path services one voice per sys_clk (round-robin TDM slot).
- Presents each voice's wavetable address, enable and waveform select to the downstream wavetable/mixer.
- Voice divider, phase offset and wavesel are written through a single config port driven by the MIDI decoder.

Parameters:
NUM_VOICES, 8, number of voices/TDM slots (2..256, need not be a power of two)
VOICE_BITS, 3, width of voice index; must satisfy 2^VOICE_BITS >= NUM_VOICES
D_W, 16, divider and per-voice count width
ADDR_W, 8, wavetable address width
MIN_DIVIDER, 8, dividers below this value disable the voice

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous assert, active-low
cfg_we  in  1  config write strobe, one cycle
cfg_voice  in  VOICE_BITS  target voice
cfg_sel  in  2  0=divider, 1=phase offset, 2=wavesel, 3=reserved (ignored)
cfg_data  in  D_W  write data; low ADDR_W bits for phase, low 2 bits for wavesel
tdm_voice_num  out  VOICE_BITS  voice serviced in this output slot
tdm_voice_addr  out  ADDR_W  wavetable address including phase offset
tdm_voice_enabled  out  1  voice divider >= MIN_DIVIDER
tdm_wavesel  out  2  voice waveform select
tdm_frame_start  out  1  high while tdm_voice_num == 0

Behaviour:
Reset (async, sys_rst_n low):
- All outputs are 0.
- Slot counter = 0.
- Per-voice state is 0: divider, phase offset, wavesel, count and base address.
- Release is synchronised internally with a 2-flop reset release; the first slot after release is voice 0.

Slot counter:
- Increments every cycle.
- Wraps from NUM_VOICES-1 to 0. Indices NUM_VOICES..2^VOICE_BITS-1 are never visited.

Per slot, for voice v = slot:
- If div[v] < MIN_DIVIDER: cnt[v] <= 0; base[v] held.
- Else if cnt[v] >= div[v]-1: cnt[v] <= 0; base[v] <= base[v]+1, wrapping mod 2^ADDR_W.
- Else: cnt[v] <= cnt[v]+1.
- Output frequency = f_sys / (NUM_VOICES * div * 2^ADDR_W).

Outputs:
- Registered, 1-cycle latency: the outputs at cycle n+1 describe slot n.
- tdm_voice_addr = (pre-update base[v] + phase[v]) mod 2^ADDR_W.
- tdm_voice_enabled = (div[v] >= MIN_DIVIDER).
- tdm_wavesel = wave[v].
- tdm_voice_num = v.
- tdm_frame_start = (v == 0).

Config writes:
- Captured on the cycle cfg_we is high.
- cfg_voice >= NUM_VOICES or cfg_sel == 3: write ignored.
- Simultaneous write to the voice currently in its slot: that slot's computation and outputs use the old values; the new value applies from the voice's next slot.
- A divider write does not touch cnt[v] or base[v] (except under PHASE_SYNC_EN).
- If the new divider is <= the current cnt[v], the next active slot wraps immediately, because the rule is >=.

Width rules:
- All additions truncate to the destination width.
- div-1 is evaluated only when div >= MIN_DIVIDER (>= 1), so it never underflows.

Reset mid-operation:
- Immediately zeroes all state.
- No partial writes survive.

Optional Feature:
Macro VOICE_PHASE_SYNC_EN.
- Defined: a divider write to voice v also sets cnt[v] <= 0 and base[v] <= 0 (hard sync at note-on). This overrides that voice's same-cycle slot update of cnt/base. The outputs for that slot still show the old values.
- Undefined: divider writes leave cnt/base untouched; free-running phase continuity.

Decomposition:
Package synth_voice_pkg:
- cfg_sel encodings (CFG_DIV, CFG_PHASE, CFG_WAVE).
- Wavesel codes.
- Default MIN_DIVIDER.

Sub-module voice_nco_step:
- Combinational next-state function.
- Inputs: div, cnt, base, phase.
- Outputs: next cnt, next base, out addr, enabled.
- Instantiated once in the shared path.

Per-voice state is held in register arrays indexed by slot; it maps to LUT/FF on the iCE40 at the default sizes.

Test Plan:
1. Reset then idle 16 cycles -> tdm_voice_num sequence 0..7,0..7; tdm_frame_start high on num 0; enabled = 0, addr = 0 throughout.
2. Write voice 2 div = 8 -> voice 2 enabled; its addr increments by 1 every 64 cycles (8 slots x div 8); wraps 255 -> 0 after 16384 cycles.
3. Write voice 2 phase = 0x80 with base 0x05 -> voice 2 addr = 0x85; with base 0xF0 -> addr = 0x70 (wrap).
4. Write voice 5 div = 7 (< MIN) -> enabled = 0, base frozen. Then write div = 0xFFFF -> enabled = 1, one increment per 8*65535 cycles.
5. Write arriving in the same cycle as voice 3's slot (div 8 -> 20) -> the slot shows the old values; the next visit uses 20. Write with cfg_voice = 7 while NUM_VOICES = 6 -> no state change.
6. With VOICE_PHASE_SYNC_EN, write voice 1 div = 10 while base = 0x40 -> next voice 1 slot addr = phase offset. Assert sys_rst_n low mid-run -> outputs 0 asynchronously.

Source files
------------

// File: rtl/synth_voice_pkg.sv
// Shared encodings for the poly-synth voice NCO bank: config selectors,
// waveform codes and default sizing.
package synth_voice_pkg;

  typedef enum logic [1:0] {
    CFG_DIV   = 2'd0,
    CFG_PHASE = 2'd1,
    CFG_WAVE  = 2'd2,
    CFG_RSVD  = 2'd3
  } cfg_sel_e;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'd0,
    WAVE_SQR = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_SIN = 2'd3
  } wave_e;

  localparam int DEF_NUM_VOICES  = 8;
  localparam int DEF_VOICE_BITS  = 3;
  localparam int DEF_D_W         = 16;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_MIN_DIVIDER = 8;

endpackage

// File: rtl/voice_nco_step.sv
// Combinational next-state of one voice NCO; shared across all TDM slots.
module voice_nco_step #(
  parameter int D_W         = 16,
  parameter int ADDR_W      = 8,
  parameter int MIN_DIVIDER = 8
) (
  input  logic [D_W-1:0]    div,
  input  logic [D_W-1:0]    cnt,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] phase,
  output logic [D_W-1:0]    cnt_nxt,
  output logic [ADDR_W-1:0] base_nxt,
  output logic [ADDR_W-1:0] addr,
  output logic              enabled
);

  always_comb begin
    enabled  = (div >= D_W'(MIN_DIVIDER));
    addr     = base + phase;
    cnt_nxt  = cnt + D_W'(1);
    base_nxt = base;
    if (!enabled) begin
      cnt_nxt = '0;
    end else if (cnt >= div - D_W'(1)) begin
      // >= rather than == so a divider shrunk below cnt wraps at once
      cnt_nxt  = '0;
      base_nxt = base + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/voice_tdm_nco_bank.sv
// Time-multiplexed bank of NUM_VOICES NCOs, one voice per clock.
// Optional VOICE_PHASE_SYNC_EN: divider writes hard-sync cnt/base to 0.
module voice_tdm_nco_bank
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES  = DEF_NUM_VOICES,
  parameter int VOICE_BITS  = DEF_VOICE_BITS,
  parameter int D_W         = DEF_D_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int MIN_DIVIDER = DEF_MIN_DIVIDER
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cfg_we,
  input  logic [VOICE_BITS-1:0] cfg_voice,
  input  logic [1:0]            cfg_sel,
  input  logic [D_W-1:0]        cfg_data,
  output logic [VOICE_BITS-1:0] tdm_voice_num,
  output logic [ADDR_W-1:0]     tdm_voice_addr,
  output logic                  tdm_voice_enabled,
  output logic [1:0]            tdm_wavesel,
  output logic                  tdm_frame_start
);

  // State arrays span the full index space so slot/cfg indexing is exact;
  // entries at or above NUM_VOICES are never written and stay constant.
  localparam int NV_PAD = 1 << VOICE_BITS;

  logic rst_meta_q, rst_sync_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic [NV_PAD-1:0][D_W-1:0]    div_q, div_d, cnt_q, cnt_d;
  logic [NV_PAD-1:0][ADDR_W-1:0] phase_q, phase_d, base_q, base_d;
  logic [NV_PAD-1:0][1:0]        wave_q, wave_d;
  logic [VOICE_BITS-1:0]         slot_q, slot_d;

  logic [VOICE_BITS-1:0] num_q, num_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  en_q, en_d;
  logic [1:0]            wsel_q, wsel_d;
  logic                  fs_q, fs_d;

  logic [D_W-1:0]    step_cnt;
  logic [ADDR_W-1:0] step_base, step_addr;
  logic              step_en;
  logic              cfg_hit;

  voice_nco_step #(
    .D_W        (D_W),
    .ADDR_W     (ADDR_W),
    .MIN_DIVIDER(MIN_DIVIDER)
  ) u_step (
    .div     (div_q[slot_q]),
    .cnt     (cnt_q[slot_q]),
    .base    (base_q[slot_q]),
    .phase   (phase_q[slot_q]),
    .cnt_nxt (step_cnt),
    .base_nxt(step_base),
    .addr    (step_addr),
    .enabled (step_en)
  );

  assign cfg_hit = cfg_we && ({1'b0, cfg_voice} < (VOICE_BITS+1)'(NUM_VOICES));

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    base_d  = base_q;
    wave_d  = wave_q;

    cnt_d[slot_q]  = step_cnt;
    base_d[slot_q] = step_base;

    // Config applied after the slot update: a same-slot write only takes
    // effect on the voice's next visit (and sync overrides the slot step).
    if (cfg_hit) begin
      case (cfg_sel_e'(cfg_sel))
        CFG_DIV: begin
          div_d[cfg_voice] = cfg_data;
`ifdef VOICE_PHASE_SYNC_EN
          cnt_d[cfg_voice]  = '0;
          base_d[cfg_voice] = '0;
`endif
        end
        CFG_PHASE: phase_d[cfg_voice] = cfg_data[ADDR_W-1:0];
        CFG_WAVE:  wave_d[cfg_voice]  = cfg_data[1:0];
        default: ;
      endcase
    end

    slot_d = (slot_q == VOICE_BITS'(NUM_VOICES-1)) ? '0 : slot_q + VOICE_BITS'(1);

    num_d  = slot_q;
    addr_d = step_addr;
    en_d   = step_en;
    wsel_d = wave_q[slot_q];
    fs_d   = (slot_q == '0);
  end

  always_ff @(posedge sys_clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      base_q  <= '0;
      wave_q  <= '0;
      slot_q  <= '0;
      num_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      wsel_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      base_q  <= base_d;
      wave_q  <= wave_d;
      slot_q  <= slot_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      wsel_q  <= wsel_d;
      fs_q    <= fs_d;
    end
  end

  assign tdm_voice_num     = num_q;
  assign tdm_voice_addr    = addr_q;
  assign tdm_voice_enabled = en_q;
  assign tdm_wavesel       = wsel_q;
  assign tdm_frame_start   = fs_q;

endmodule
